// File: rtl/ntt_arb_pkg.sv
// Shared types for the NTT coefficient-memory arbiter: grant states, owner
// encoding and the read-return tag that rides the latency pipe.
package ntt_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_NTT  = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        G_HOST = 2'd1,
        G_NTT  = 2'd2
    } state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    function automatic owner_e state_to_owner(input state_e s);
        case (s)
            G_HOST:  return OWN_HOST;
            G_NTT:   return OWN_NTT;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ntt_rd_tag_pipe.sv
// Fixed-latency tag pipe: carries {valid, owner} of each read beat so the
// returning memory data can be steered to the requester that issued it.
module ntt_rd_tag_pipe
    import ntt_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t i_tag,
    output logic    o_host_rvalid,
    output logic    o_ntt_rvalid
);

    rd_tag_t r_pipe [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_host_rvalid = r_pipe[RD_LAT-1].valid && (r_pipe[RD_LAT-1].owner == OWN_HOST);
    assign o_ntt_rvalid  = r_pipe[RD_LAT-1].valid && (r_pipe[RD_LAT-1].owner == OWN_NTT);

endmodule

// File: rtl/ntt_mem_arbiter.sv
// Burst-locked arbiter sharing one single-port coefficient memory between the
// host load/unload path and the NTT engine, with priority, round-robin and
// starvation override.
module ntt_mem_arbiter
    import ntt_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned BURST_MAX    = 16,
    parameter int unsigned STARVE_LIMIT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ntt_prio,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    input  logic              i_host_last,
    output logic              o_host_gnt,
    output logic              o_host_rvalid,
    input  logic              i_ntt_req,
    input  logic              i_ntt_we,
    input  logic [ADDR_W-1:0] i_ntt_addr,
    input  logic [DATA_W-1:0] i_ntt_wdata,
    input  logic              i_ntt_last,
    output logic              o_ntt_gnt,
    output logic              o_ntt_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [1:0]        o_owner
);

    localparam int unsigned BEAT_W   = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    state_e              r_state;
    state_e              w_next_state;
    state_e              w_pick;
    owner_e              r_last_owner;
    owner_e              w_prev_owner;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [STARVE_W-1:0] r_starve_host;
    logic [STARVE_W-1:0] r_starve_ntt;

    logic    w_host_gnt;
    logic    w_ntt_gnt;
    logic    w_beat;
    logic    w_own_last;
    logic    w_max_end;
    logic    w_burst_end;
    logic    w_abort;
    logic    w_rearb;
    logic    w_cand_host;
    logic    w_cand_ntt;
    logic    w_host_starved;
    logic    w_ntt_starved;
    rd_tag_t w_tag;

    assign w_host_gnt  = (r_state == G_HOST) && i_host_req;
    assign w_ntt_gnt   = (r_state == G_NTT)  && i_ntt_req;
    assign w_beat      = w_host_gnt || w_ntt_gnt;
    assign w_own_last  = (w_host_gnt && i_host_last) || (w_ntt_gnt && i_ntt_last);
    assign w_max_end   = w_beat && (r_beat_cnt == BEAT_W'(BURST_MAX - 1));
    assign w_burst_end = w_own_last || w_max_end;
    assign w_abort     = ((r_state == G_HOST) && !i_host_req && i_ntt_req) ||
                         ((r_state == G_NTT)  && !i_ntt_req  && i_host_req);
    assign w_rearb     = (r_state == IDLE) || w_burst_end || w_abort;

    // A request seen on a beat flagged last belongs to that beat, not to a new burst.
    assign w_cand_host = i_host_req && !(w_host_gnt && i_host_last);
    assign w_cand_ntt  = i_ntt_req  && !(w_ntt_gnt  && i_ntt_last);

    assign w_host_starved = (r_starve_host >= STARVE_W'(STARVE_LIMIT));
    assign w_ntt_starved  = (r_starve_ntt  >= STARVE_W'(STARVE_LIMIT));
    assign w_prev_owner   = (r_state == IDLE) ? r_last_owner : state_to_owner(r_state);

    // Arbitration pick: starvation, then NTT priority, then round-robin.
    always_comb begin
        w_pick = IDLE;
        if (w_cand_host && w_host_starved && !(w_cand_ntt && w_ntt_starved)) begin
            w_pick = G_HOST;
        end else if (w_cand_ntt && w_ntt_starved && !(w_cand_host && w_host_starved)) begin
            w_pick = G_NTT;
        end else if (w_cand_ntt && i_ntt_prio) begin
            w_pick = G_NTT;
        end else if (w_cand_host && w_cand_ntt) begin
            w_pick = (w_prev_owner == OWN_HOST) ? G_NTT : G_HOST;
        end else if (w_cand_host) begin
            w_pick = G_HOST;
        end else if (w_cand_ntt) begin
            w_pick = G_NTT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_rearb) begin
            w_next_state = w_pick;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_owner <= OWN_NONE;
            r_beat_cnt   <= '0;
        end else begin
            if (r_state != IDLE) begin
                r_last_owner <= state_to_owner(r_state);
            end
            if (w_rearb) begin
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
        end
    end

    // Per-requester wait counters, saturating at the starvation limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_host <= '0;
            r_starve_ntt  <= '0;
        end else begin
            if (w_host_gnt) begin
                r_starve_host <= '0;
            end else if (i_host_req && !w_host_starved) begin
                r_starve_host <= r_starve_host + STARVE_W'(1);
            end
            if (w_ntt_gnt) begin
                r_starve_ntt <= '0;
            end else if (i_ntt_req && !w_ntt_starved) begin
                r_starve_ntt <= r_starve_ntt + STARVE_W'(1);
            end
        end
    end

    always_comb begin
        o_mem_en    = w_beat;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (r_state)
            G_HOST: begin
                o_mem_we    = w_host_gnt && i_host_we;
                o_mem_addr  = i_host_addr;
                o_mem_wdata = i_host_wdata;
            end
            G_NTT: begin
                o_mem_we    = w_ntt_gnt && i_ntt_we;
                o_mem_addr  = i_ntt_addr;
                o_mem_wdata = i_ntt_wdata;
            end
            default: ;
        endcase
    end

    assign o_host_gnt = w_host_gnt;
    assign o_ntt_gnt  = w_ntt_gnt;
    assign o_owner    = state_to_owner(r_state);
    assign o_rdata    = i_mem_rdata;

    assign w_tag.valid = w_beat && !o_mem_we;
    assign w_tag.owner = state_to_owner(r_state);

    ntt_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk           (clk),
        .rst           (rst),
        .i_tag         (w_tag),
        .o_host_rvalid (o_host_rvalid),
        .o_ntt_rvalid  (o_ntt_rvalid)
    );

endmodule

// File: tb/tb_ntt_mem_arbiter.sv
// Directed bench for ntt_mem_arbiter: reset, bursts, priority, burst cap,
// starvation override and tagged read return (RD_LAT=2).
module tb_ntt_mem_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              ntt_prio;
    logic              host_req, host_we, host_last;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              ntt_req, ntt_we, ntt_last;
    logic [ADDR_W-1:0] ntt_addr;
    logic [DATA_W-1:0] ntt_wdata;
    logic              host_gnt, host_rvalid, ntt_gnt, ntt_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        owner;

    logic [ADDR_W-1:0] r_a1, r_a2;

    int n_chk = 0;
    int n_err = 0;
    int beats;
    logic got;

    always #5 clk = ~clk;

    // Memory model: two-cycle read, data is a tagged copy of the address.
    always @(posedge clk) begin
        r_a1 <= mem_addr;
        r_a2 <= r_a1;
    end
    assign mem_rdata = 64'hC0DE_0000_0000_0000 | 64'(r_a2);

    ntt_mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .RD_LAT       (RD_LAT),
        .BURST_MAX    (16),
        .STARVE_LIMIT (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_ntt_prio    (ntt_prio),
        .i_host_req    (host_req),
        .i_host_we     (host_we),
        .i_host_addr   (host_addr),
        .i_host_wdata  (host_wdata),
        .i_host_last   (host_last),
        .o_host_gnt    (host_gnt),
        .o_host_rvalid (host_rvalid),
        .i_ntt_req     (ntt_req),
        .i_ntt_we      (ntt_we),
        .i_ntt_addr    (ntt_addr),
        .i_ntt_wdata   (ntt_wdata),
        .i_ntt_last    (ntt_last),
        .o_ntt_gnt     (ntt_gnt),
        .o_ntt_rvalid  (ntt_rvalid),
        .o_rdata       (rdata),
        .o_mem_en      (mem_en),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .o_owner       (owner)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ntt_prio   = 1'b0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        host_last  = 1'b0;
        ntt_req    = 1'b0;
        ntt_we     = 1'b0;
        ntt_addr   = '0;
        ntt_wdata  = '0;
        ntt_last   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset values, with a request pending during reset
        idle_inputs();
        rst = 1'b1;
        host_req = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_ntt_gnt", ntt_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_owner", owner, 0);
        chk("rst_rvalid", {host_rvalid, ntt_rvalid}, 0);

        // Reset asserted mid-burst with a read in flight
        do_reset();
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h3;
        @(negedge clk);
        #1;
        chk("mid_gnt_before", host_gnt, 1);
        @(negedge clk);
        host_addr = 10'h4;
        rst = 1'b1;
        #1;
        chk("mid_gnt_drop", host_gnt, 0);
        chk("mid_mem_en_drop", mem_en, 0);
        chk("mid_owner", owner, 0);
        @(negedge clk);
        rst = 1'b0;
        host_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mid_no_rvalid", {host_rvalid, ntt_rvalid}, 0);
            @(negedge clk);
        end

        // Single HOST write burst of four beats
        do_reset();
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'h10; host_wdata = 64'h100;
        #1;
        chk("hb_idle_gnt", host_gnt, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            host_addr  = ADDR_W'(16 + i);
            host_wdata = 64'(256 + i);
            host_last  = (i == 3);
            #1;
            chk("hb_gnt", host_gnt, 1);
            chk("hb_mem_en", mem_en, 1);
            chk("hb_mem_we", mem_we, 1);
            chk("hb_mem_addr", mem_addr, 64'(16 + i));
            chk("hb_mem_wdata", mem_wdata, 64'(256 + i));
            chk("hb_owner", owner, 1);
        end
        @(negedge clk);
        host_req = 1'b0; host_last = 1'b0;
        #1;
        chk("hb_after_owner", owner, 0);
        chk("hb_after_mem_en", mem_en, 0);

        // NTT priority, then direct handover to HOST
        do_reset();
        ntt_prio = 1'b1;
        host_req = 1'b1; host_we = 1'b1;
        ntt_req = 1'b1; ntt_we = 1'b1;
        #1;
        chk("pr_idle_gnts", {host_gnt, ntt_gnt}, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ntt_addr = ADDR_W'(32 + i);
            ntt_last = (i == 7);
            #1;
            chk("pr_ntt_gnt", {host_gnt, ntt_gnt}, 2'b01);
        end
        @(negedge clk);
        ntt_req = 1'b0; ntt_last = 1'b0; host_last = 1'b1;
        #1;
        chk("pr_handover_gnt", host_gnt, 1);
        chk("pr_handover_owner", owner, 1);
        @(negedge clk);
        host_req = 1'b0; host_last = 1'b0;
        #1;
        chk("pr_end_owner", owner, 0);

        // Round-robin alternation with single-beat bursts
        do_reset();
        host_req = 1'b1; host_last = 1'b1;
        ntt_req = 1'b1; ntt_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rr_owner", owner, (i == 1) ? 2 : 1);
            chk("rr_host_gnt", host_gnt, (i == 1) ? 0 : 1);
        end

        // BURST_MAX forces handover after the 16th NTT beat
        do_reset();
        ntt_req = 1'b1; ntt_we = 1'b1;
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1;
        beats = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (ntt_gnt) beats++;
            @(negedge clk);
        end
        host_last = 1'b1;
        #1;
        chk("bm_ntt_beats", 64'(beats), 16);
        chk("bm_host_gnt", {host_gnt, ntt_gnt}, 2'b10);
        chk("bm_owner", owner, 1);
        @(negedge clk);
        #1;
        chk("bm_ntt_resume", ntt_gnt, 1);

        // Starvation override against continuous NTT priority traffic
        do_reset();
        ntt_prio = 1'b1;
        host_req = 1'b1; host_we = 1'b1;
        ntt_req = 1'b1; ntt_we = 1'b1;
        beats = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #1;
            if (host_gnt) got = 1'b1;
            else if (ntt_gnt) beats++;
        end
        chk("sv_host_granted", got, 1);
        chk("sv_ntt_beats", 64'(beats), 32);

        // Read return with RD_LAT=2, HOST then NTT
        do_reset();
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h5; host_last = 1'b1;
        @(negedge clk);
        #1;
        chk("rd_host_gnt", host_gnt, 1);
        chk("rd_mem_we", mem_we, 0);
        @(negedge clk);
        host_req = 1'b0; host_last = 1'b0;
        #1;
        chk("rd_t1_rvalid", {host_rvalid, ntt_rvalid}, 0);
        @(negedge clk);
        #1;
        chk("rd_t2_host_rvalid", host_rvalid, 1);
        chk("rd_t2_ntt_rvalid", ntt_rvalid, 0);
        chk("rd_t2_rdata", rdata, 64'hC0DE_0000_0000_0005);
        @(negedge clk);
        ntt_req = 1'b1; ntt_we = 1'b0; ntt_addr = 10'h7; ntt_last = 1'b1;
        #1;
        chk("rd_t3_rvalid", {host_rvalid, ntt_rvalid}, 0);
        @(negedge clk);
        #1;
        chk("rd_ntt_gnt", ntt_gnt, 1);
        @(negedge clk);
        ntt_req = 1'b0; ntt_last = 1'b0;
        @(negedge clk);
        #1;
        chk("rd_ntt_rvalid", {host_rvalid, ntt_rvalid}, 2'b01);
        chk("rd_ntt_rdata", rdata, 64'hC0DE_0000_0000_0007);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
